// File: rtl/mem_pkg.sv
// Shared types and constants for the cache-side main memory responder.
package mem_pkg;

  localparam int WORD_W              = 16;
  localparam int BLOCK_WORDS         = 8;
  localparam int DEFAULT_MEM_LATENCY = 4;
  localparam int ADDR_W              = 16;

  typedef logic [WORD_W-1:0] mem_word_t;

  // One in-flight read: valid flag plus the word-aligned byte address.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } mem_req_t;

  // Byte address with bit 0 cleared (16-bit words).
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_delay_pipe.sv
// Delay line for read requests. Holds the LATENCY-1 stages that precede the
// response register in the top; o_tail is the request whose array read is
// taken at the current edge. For LATENCY=1 the incoming request is the tail.
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_req_t i_req,
  output mem_req_t o_tail,
  output logic     o_pending
);

  if (LATENCY > 1) begin : g_pipe
    localparam int N = LATENCY - 1;
    mem_req_t r_stage [N];
    logic     w_any;

    // First stage captures the request at the edge that accepts it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_stage[0] <= '0;
      else     r_stage[0] <= i_req;
    end

    for (genvar gi = 1; gi < N; gi++) begin : g_stage
      // Each later stage shifts its predecessor forward one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_stage[gi] <= '0;
        else     r_stage[gi] <= r_stage[gi-1];
      end
    end

    // Any valid stage means a read is still in flight.
    always_comb begin
      w_any = 1'b0;
      for (int k = 0; k < N; k++) w_any = w_any | r_stage[k].valid;
    end

    assign o_tail    = r_stage[N-1];
    assign o_pending = w_any;
  end else begin : g_direct
    assign o_tail    = i_req;
    assign o_pending = 1'b0;
  end

endmodule

// File: rtl/multicycle_mem_responder.sv
// Main-memory responder for cache fills and write-throughs. Writes land at the
// accepting edge; reads return after LATENCY cycles, fully pipelined.
// Optional macro MEM_INIT_EN zero-fills the array at time zero.
module multicycle_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY    = DEFAULT_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_MemRead,
  input  logic                  cache_MemWrite,
  input  logic [ADDR_WIDTH-1:0] cache_mem_addr,
  input  logic [WORD_W-1:0]     mem_write_data,
  output logic                  MemDataValid,
  output logic [WORD_W-1:0]     mem_read_data,
  output logic [ADDR_WIDTH-1:0] mem_resp_addr,
  output logic                  mem_pending
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  mem_word_t             r_mem [DEPTH];
  logic                  r_valid;
  mem_word_t             r_data;
  logic [ADDR_WIDTH-1:0] r_addr;

  mem_req_t              w_req;
  mem_req_t              w_tail;
  logic                  w_pending;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [DEPTH_LOG2-1:0] w_rd_idx;

  // Index bits above DEPTH_LOG2 are dropped, so high addresses alias.
  assign w_wr_idx = cache_mem_addr[DEPTH_LOG2:1];
  assign w_rd_idx = w_tail.addr[DEPTH_LOG2:1];

  // A read issued together with a write is discarded; the write wins.
  assign w_req = '{valid: cache_MemRead & ~cache_MemWrite,
                   addr:  word_align(cache_mem_addr)};

  mem_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .o_tail   (w_tail),
    .o_pending(w_pending)
  );

`ifdef MEM_INIT_EN
  // Zero-fill the array so unlisted words read as 0.
  initial begin
    for (int k = 0; k < DEPTH; k++) r_mem[k] = '0;
  end
`endif

  // Array write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (cache_MemWrite) r_mem[w_wr_idx] <= mem_write_data;
  end

  // Response register: samples the array before this edge's write lands,
  // and holds data/address while no response is being launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
    end else begin
      r_valid <= w_tail.valid;
      if (w_tail.valid) begin
        r_data <= r_mem[w_rd_idx];
        r_addr <= w_tail.addr;
      end
    end
  end

  assign MemDataValid  = r_valid;
  assign mem_read_data = r_data;
  assign mem_resp_addr = r_addr;
  assign mem_pending   = w_pending;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed bench for multicycle_mem_responder (LATENCY=4).
// Inputs change 1ns after a rising edge; "cycle n" is the interval that edge
// opens, and outputs are sampled in the same place.
module tb_multicycle_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cache_MemRead = 1'b0;
  logic        cache_MemWrite = 1'b0;
  logic [15:0] cache_mem_addr = '0;
  logic [15:0] mem_write_data = '0;
  logic        MemDataValid;
  logic [15:0] mem_read_data;
  logic [15:0] mem_resp_addr;
  logic        mem_pending;

  int checks = 0;
  int errors = 0;

  multicycle_mem_responder #(.ADDR_WIDTH(16), .DEPTH_LOG2(15), .LATENCY(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cache_MemRead (cache_MemRead),
    .cache_MemWrite(cache_MemWrite),
    .cache_mem_addr(cache_mem_addr),
    .mem_write_data(mem_write_data),
    .MemDataValid  (MemDataValid),
    .mem_read_data (mem_read_data),
    .mem_resp_addr (mem_resp_addr),
    .mem_pending   (mem_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    cache_MemRead  = rd;
    cache_MemWrite = wr;
    cache_mem_addr = a;
    mem_write_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic [15:0] d, input logic [15:0] a);
    check({tag, "_valid"}, {15'd0, MemDataValid}, 16'd1);
    check({tag, "_data"}, mem_read_data, d);
    check({tag, "_addr"}, mem_resp_addr, a);
    $display("resp %s data=%h addr=%h", tag, mem_read_data, mem_resp_addr);
  endtask

  initial begin
    // ---- reset state
    tick(); tick();
    check("rst_valid", {15'd0, MemDataValid}, 16'd0);
    check("rst_data", mem_read_data, 16'h0000);
    check("rst_addr", mem_resp_addr, 16'h0000);
    check("rst_pending", {15'd0, mem_pending}, 16'd0);
    rst = 1'b0;
    tick();

    // ---- basic latency: write c0, read c2, valid only c6
    drive(1'b0, 1'b1, 16'h0010, 16'h00AA); tick();   // c1
    idle(); tick();                                  // c2
    drive(1'b1, 1'b0, 16'h0010, 16'h0000); tick();   // c3
    idle();
    check("lat_c3_pending", {15'd0, mem_pending}, 16'd1);
    check("lat_c3_valid", {15'd0, MemDataValid}, 16'd0);
    tick(); check("lat_c4_valid", {15'd0, MemDataValid}, 16'd0);
    tick(); check("lat_c5_valid", {15'd0, MemDataValid}, 16'd0);
    tick(); check_resp("lat_c6", 16'h00AA, 16'h0010);
    tick(); check("lat_c7_valid", {15'd0, MemDataValid}, 16'd0);
    check("lat_c7_hold", mem_read_data, 16'h00AA);
    tick();

    // ---- block fill: words 1..8 at 0x0000..0x000E
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 16'(2 * i), 16'(i + 1)); tick();
    end
    idle(); tick();
    for (int c = 0; c < 14; c++) begin
      if (c < 8) drive(1'b1, 1'b0, 16'(2 * c), 16'h0000);
      else       idle();
      tick();   // now in cycle c+1
      check($sformatf("fill_c%0d_pending", c + 1), {15'd0, mem_pending},
            (c + 1 <= 10) ? 16'd1 : 16'd0);
      if (c + 1 >= 4 && c + 1 <= 11)
        check_resp($sformatf("fill_c%0d", c + 1), 16'(c - 2), 16'(2 * (c - 3)));
      else
        check($sformatf("fill_c%0d_valid", c + 1), {15'd0, MemDataValid}, 16'd0);
    end

    // ---- hazard: write in c2 is visible
    drive(1'b0, 1'b1, 16'h0020, 16'h0005); tick();
    idle(); tick();
    drive(1'b1, 1'b0, 16'h0020, 16'h0000); tick();   // c1
    idle(); tick();                                  // c2
    drive(1'b0, 1'b1, 16'h0020, 16'h0009); tick();   // c3
    idle(); tick();                                  // c4
    check_resp("haz_early_write", 16'h0009, 16'h0020);

    // ---- hazard: write at sampling edge (c3) is not visible
    drive(1'b0, 1'b1, 16'h0020, 16'h0005); tick();
    idle(); tick();
    drive(1'b1, 1'b0, 16'h0020, 16'h0000); tick();   // c1
    idle(); tick(); tick();                          // c3
    drive(1'b0, 1'b1, 16'h0020, 16'h0009); tick();   // c4
    idle();
    check_resp("haz_same_edge", 16'h0005, 16'h0020);
    tick();

    // ---- simultaneous read+write: write lands, read dropped
    drive(1'b1, 1'b1, 16'h0030, 16'h0007); tick();
    idle();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("rw_c%0d_valid", c + 1), {15'd0, MemDataValid}, 16'd0);
      check($sformatf("rw_c%0d_pending", c + 1), {15'd0, mem_pending}, 16'd0);
      tick();
    end
    drive(1'b1, 1'b0, 16'h0030, 16'h0000); tick();
    idle(); tick(); tick(); tick();
    check_resp("rw_later_read", 16'h0007, 16'h0030);
    tick();

    // ---- reset mid-fill: reads c0..c4, async reset inside c5
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 16'(2 * c), 16'h0000); tick();   // now c+1
    end
    // now in cycle 5; the c0 and c1 responses have come out
    idle();
    check_resp("rstmid_c5_pre", 16'h0002, 16'h0002);
    #1 rst = 1'b1;
    #1;
    check("rstmid_valid", {15'd0, MemDataValid}, 16'd0);
    check("rstmid_data", mem_read_data, 16'h0000);
    check("rstmid_addr", mem_resp_addr, 16'h0000);
    check("rstmid_pending", {15'd0, mem_pending}, 16'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("rstmid_after%0d_valid", c), {15'd0, MemDataValid}, 16'd0);
      check($sformatf("rstmid_after%0d_data", c), mem_read_data, 16'h0000);
    end
    drive(1'b1, 1'b0, 16'h0006, 16'h0000); tick();
    idle(); tick(); tick(); tick();
    check_resp("rstmid_preserved", 16'h0004, 16'h0006);
    tick();

    // ---- odd byte address behaves like the even one
    drive(1'b1, 1'b0, 16'h0011, 16'h0000); tick();
    idle(); tick(); tick(); tick();
    check_resp("odd_addr", 16'h00AA, 16'h0010);
    tick();
    check("odd_idle_valid", {15'd0, MemDataValid}, 16'd0);
    check("odd_idle_hold_addr", mem_resp_addr, 16'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
